// File: rtl/keypad_pkg.sv
// Shared constants, segment table and debounce state type for the keypad entry display.
package keypad_pkg;

  localparam logic [3:0] KEY_BACK  = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry 15 is the leftmost element.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_CHK,
    DB_HELD,
    DB_REL_CHK
  } db_state_e;

  function automatic logic [7:0] seg_lookup(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces per-scan key reports into single press events; no auto-repeat.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done,
  input  logic       key_hit,
  input  logic [3:0] key_code,
  output logic       accept_c,
  output logic       key_event,
  output logic [3:0] key_last
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_SCANS);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             key_event_q, key_event_d;
  logic [3:0]       key_last_q, key_last_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             same_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DB_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_event_q <= 1'b0;
      key_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_event_q <= key_event_d;
      key_last_q  <= key_last_d;
    end
  end

  // Next-state logic; only scan_done cycles advance the FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_c = 1'b0;
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    same_hit = key_hit && (key_code == cand_q);

    if (scan_done) begin
      unique case (state_q)
        DB_IDLE: begin
          if (key_hit) begin
            cand_d = key_code;
            cnt_d  = CNT_W'(1);
            if (DB_TARGET <= CNT_W'(1)) begin
              state_d  = DB_HELD;
              accept_c = 1'b1;
            end else begin
              state_d = DB_PRESS_CHK;
            end
          end
        end
        DB_PRESS_CHK: begin
          if (!key_hit) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else if (same_hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_TARGET) begin
              state_d  = DB_HELD;
              accept_c = 1'b1;
            end
          end else begin
            cand_d = key_code;
            cnt_d  = CNT_W'(1);
          end
        end
        DB_HELD: begin
          if (!same_hit) begin
            state_d = DB_REL_CHK;
            cnt_d   = CNT_W'(1);
          end
        end
        DB_REL_CHK: begin
          if (same_hit) begin
            state_d = DB_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_TARGET) begin
              state_d = DB_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = DB_IDLE;
      endcase
    end

    key_event_d = accept_c;
    key_last_d  = accept_c ? key_code : key_last_q;
  end

  assign key_event = key_event_q;
  assign key_last  = key_last_q;

endmodule

// File: rtl/seg7_decode.sv
// Registered active-low seven-segment decode for one display digit.
module seg7_decode
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] seg_q, seg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  always_comb begin
    seg_d = blank ? SEG_BLANK : seg_lookup(digit);
  end

  assign seg = seg_q;

endmodule

// File: rtl/keypad_entry_display.sv
// Keypad entry buffer with backspace/clear, driving the active-low HEX displays.
module keypad_entry_display
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned NUM_DIGITS     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_done,
  input  logic                    key_hit,
  input  logic [3:0]              key_code,
  output logic                    key_event,
  output logic [3:0]              key_last,
  output logic [2:0]              entry_count,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  localparam int unsigned COUNT_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(NUM_DIGITS);

  logic                        accept_c;
  logic [NUM_DIGITS-1:0][3:0]  digit_q, digit_d;
  logic [COUNT_W-1:0]          count_q, count_d;

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_done(scan_done),
    .key_hit  (key_hit),
    .key_code (key_code),
    .accept_c (accept_c),
    .key_event(key_event),
    .key_last (key_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      count_q <= '0;
    end else begin
      digit_q <= digit_d;
      count_q <= count_d;
    end
  end

  // Buffer update in the same cycle the press is accepted; key_code still holds the code.
  always_comb begin
    digit_d = digit_q;
    count_d = count_q;
    if (accept_c) begin
      if (key_code == KEY_CLEAR) begin
        digit_d = '0;
        count_d = '0;
      end else if (key_code == KEY_BACK) begin
        if (count_q != '0) begin
          for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
            digit_d[i] = digit_q[i+1];
          end
          digit_d[NUM_DIGITS-1] = '0;
          count_d = count_q - COUNT_W'(1);
        end
      end else begin
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
          digit_d[i] = digit_q[i-1];
        end
        digit_d[0] = key_code;
        count_d = (count_q >= COUNT_MAX) ? COUNT_MAX : count_q + COUNT_W'(1);
      end
    end
  end

  // Positions at or above the entry count show blank.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    localparam logic [COUNT_W-1:0] POS = COUNT_W'(g);
    seg7_decode u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .digit(digit_q[g]),
      .blank(POS >= count_q),
      .seg  (hex_out[8*g +: 8])
    );
  end

  assign entry_count = count_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed self-checking bench for keypad_entry_display with default parameters.
module tb_keypad_entry_display;

  logic        clk;
  logic        rst_n;
  logic        scan_done;
  logic        key_hit;
  logic [3:0]  key_code;
  logic        key_event;
  logic [3:0]  key_last;
  logic [2:0]  entry_count;
  logic [47:0] hex_out;

  int n_cmp;
  int n_bad;
  int ev_cnt;
  int ev_base;
  logic prev_event;
  logic consec_seen;

  keypad_entry_display #(
    .DEBOUNCE_SCANS(3),
    .NUM_DIGITS    (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_done  (scan_done),
    .key_hit    (key_hit),
    .key_code   (key_code),
    .key_event  (key_event),
    .key_last   (key_last),
    .entry_count(entry_count),
    .hex_out    (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ev_cnt      = 0;
    prev_event  = 1'b0;
    consec_seen = 1'b0;
  end

  always @(negedge clk) begin
    if (key_event === 1'b1) ev_cnt = ev_cnt + 1;
    if (key_event === 1'b1 && prev_event) consec_seen = 1'b1;
    prev_event = (key_event === 1'b1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; scan_done = 1'b0; key_hit = 1'b0; key_code = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic scan(input logic hit, input logic [3:0] code);
    @(negedge clk);
    scan_done = 1'b1; key_hit = hit; key_code = code;
    @(negedge clk);
    scan_done = 1'b0; key_hit = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    repeat (3) scan(1'b1, code);
    repeat (3) scan(1'b0, 4'h0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (key_event !== 1'b0) begin n_bad++; $display("FAIL reset_event got %b want 0", key_event); end
    n_cmp++; if (key_last !== 4'h0) begin n_bad++; $display("FAIL reset_last got %h want 0", key_last); end
    n_cmp++; if (entry_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", entry_count); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_hex got %h want ffffffffffff", hex_out); end
  endtask

  task automatic test_single_press();
    do_reset();
    ev_base = ev_cnt;
    repeat (2) scan(1'b1, 4'h5);
    @(negedge clk);
    scan_done = 1'b1; key_hit = 1'b1; key_code = 4'h5;
    @(negedge clk);
    n_cmp++; if (key_event !== 1'b1) begin n_bad++; $display("FAIL press_event_n1 got %b want 1", key_event); end
    n_cmp++; if (entry_count !== 3'd1) begin n_bad++; $display("FAIL press_count_n1 got %0d want 1", entry_count); end
    n_cmp++; if (hex_out[7:0] !== 8'hFF) begin n_bad++; $display("FAIL press_hex0_n1 got %h want ff", hex_out[7:0]); end
    scan_done = 1'b0; key_hit = 1'b0;
    @(negedge clk);
    n_cmp++; if (key_event !== 1'b0) begin n_bad++; $display("FAIL press_event_n2 got %b want 0", key_event); end
    n_cmp++; if (hex_out[7:0] !== 8'h92) begin n_bad++; $display("FAIL press_hex0_n2 got %h want 92", hex_out[7:0]); end
    repeat (3) scan(1'b0, 4'h0);
    n_cmp++; if (ev_cnt - ev_base !== 1) begin n_bad++; $display("FAIL press_events got %0d want 1", ev_cnt - ev_base); end
    n_cmp++; if (key_last !== 4'h5) begin n_bad++; $display("FAIL press_last got %h want 5", key_last); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FF92) begin n_bad++; $display("FAIL press_hex got %h want ffffffffff92", hex_out); end
  endtask

  task automatic test_short_press();
    do_reset();
    ev_base = ev_cnt;
    repeat (2) scan(1'b1, 4'h7);
    scan(1'b0, 4'h0);
    n_cmp++; if (ev_cnt - ev_base !== 0) begin n_bad++; $display("FAIL short_events got %0d want 0", ev_cnt - ev_base); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL short_hex got %h want ffffffffffff", hex_out); end
  endtask

  task automatic test_fill();
    do_reset();
    ev_base = ev_cnt;
    for (int k = 1; k <= 7; k++) press(4'(k));
    n_cmp++; if (ev_cnt - ev_base !== 7) begin n_bad++; $display("FAIL fill_events got %0d want 7", ev_cnt - ev_base); end
    n_cmp++; if (entry_count !== 3'd6) begin n_bad++; $display("FAIL fill_count got %0d want 6", entry_count); end
    n_cmp++; if (hex_out !== 48'hA4B0_9992_82F8) begin n_bad++; $display("FAIL fill_hex got %h want a4b0999282f8", hex_out); end
    n_cmp++; if (key_last !== 4'h7) begin n_bad++; $display("FAIL fill_last got %h want 7", key_last); end
  endtask

  task automatic test_backspace_clear();
    do_reset();
    press(4'h1);
    press(4'h2);
    press(4'hE);
    n_cmp++; if (entry_count !== 3'd1) begin n_bad++; $display("FAIL bksp_count got %0d want 1", entry_count); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFF9) begin n_bad++; $display("FAIL bksp_hex got %h want fffffffffff9", hex_out); end
    press(4'hF);
    n_cmp++; if (entry_count !== 3'd0) begin n_bad++; $display("FAIL clear_count got %0d want 0", entry_count); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL clear_hex got %h want ffffffffffff", hex_out); end
    press(4'hE);
    n_cmp++; if (entry_count !== 3'd0) begin n_bad++; $display("FAIL bksp_empty_count got %0d want 0", entry_count); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL bksp_empty_hex got %h want ffffffffffff", hex_out); end
    n_cmp++; if (key_last !== 4'hE) begin n_bad++; $display("FAIL bksp_last got %h want e", key_last); end
  endtask

  task automatic test_hold();
    do_reset();
    ev_base = ev_cnt;
    repeat (20) scan(1'b1, 4'h3);
    scan(1'b0, 4'h0);
    scan(1'b1, 4'h3);
    repeat (3) scan(1'b1, 4'h8);
    repeat (3) scan(1'b0, 4'h0);
    n_cmp++; if (ev_cnt - ev_base !== 1) begin n_bad++; $display("FAIL hold_events got %0d want 1", ev_cnt - ev_base); end
    n_cmp++; if (key_last !== 4'h3) begin n_bad++; $display("FAIL hold_last got %h want 3", key_last); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFB0) begin n_bad++; $display("FAIL hold_hex got %h want ffffffffffb0", hex_out); end
    press(4'h9);
    n_cmp++; if (ev_cnt - ev_base !== 2) begin n_bad++; $display("FAIL hold_idle_events got %0d want 2", ev_cnt - ev_base); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_B090) begin n_bad++; $display("FAIL hold_idle_hex got %h want ffffffffb090", hex_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 4; k++) press(4'(k));
    n_cmp++; if (entry_count !== 3'd4) begin n_bad++; $display("FAIL mid_pre_count got %0d want 4", entry_count); end
    repeat (2) scan(1'b1, 4'h6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (entry_count !== 3'd0) begin n_bad++; $display("FAIL mid_rst_count got %0d want 0", entry_count); end
    n_cmp++; if (key_last !== 4'h0) begin n_bad++; $display("FAIL mid_rst_last got %h want 0", key_last); end
    n_cmp++; if (key_event !== 1'b0) begin n_bad++; $display("FAIL mid_rst_event got %b want 0", key_event); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL mid_rst_hex got %h want ffffffffffff", hex_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ev_base = ev_cnt;
    repeat (2) scan(1'b1, 4'h6);
    n_cmp++; if (ev_cnt - ev_base !== 0) begin n_bad++; $display("FAIL mid_post_events got %0d want 0", ev_cnt - ev_base); end
    n_cmp++; if (entry_count !== 3'd0) begin n_bad++; $display("FAIL mid_post_count got %0d want 0", entry_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ev_base = ev_cnt;
    @(negedge clk);
    scan_done = 1'b1; key_hit = 1'b1; key_code = 4'h4;
    repeat (3) @(negedge clk);
    key_hit = 1'b0;
    repeat (3) @(negedge clk);
    key_hit = 1'b1;
    repeat (3) @(negedge clk);
    scan_done = 1'b0; key_hit = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ev_cnt - ev_base !== 2) begin n_bad++; $display("FAIL b2b_events got %0d want 2", ev_cnt - ev_base); end
    n_cmp++; if (entry_count !== 3'd2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", entry_count); end
    n_cmp++; if (hex_out !== 48'hFFFF_FFFF_9999) begin n_bad++; $display("FAIL b2b_hex got %h want ffffffff9999", hex_out); end
    n_cmp++; if (consec_seen !== 1'b0) begin n_bad++; $display("FAIL consecutive_events got %b want 0", consec_seen); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    scan_done = 1'b0;
    key_hit = 1'b0;
    key_code = 4'h0;
    test_reset();
    test_single_press();
    test_short_press();
    test_fill();
    test_backspace_clear();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_display.md
# keypad_entry_display

Downstream consumer of the 4x4 keypad scanner on the DE10-Lite. It takes the per-scan key report, debounces it into single press events, and maintains a six-digit entry buffer with clear and backspace keys. It drives the six active-low HEX displays directly, so it sits between the scanner and the board's seven-segment pins.

## Interface
- `DEBOUNCE_SCANS`, default 3: consecutive identical scans required to accept a press or a release; legal range 1–15.
- `NUM_DIGITS`, default 6: number of buffer digits and HEX displays.
- `clk` in 1: 50 MHz board clock; one clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `scan_done` in 1: one-cycle pulse when the scanner completes a full four-column sweep.
- `key_hit` in 1: sampled with `scan_done`; 1 means a key was detected during that sweep.
- `key_code` in 4: sampled with `scan_done` when `key_hit`=1. Codes 0–9 and A–D are digits, E is backspace, F is clear.
- `key_event` out 1: one-cycle pulse when a debounced press is accepted.
- `key_last` out 4: code of the last accepted press.
- `entry_count` out 3: number of valid digits in the buffer, 0..NUM_DIGITS.
- `hex_out` out 8*NUM_DIGITS: active-low segments, byte i drives HEXi. Bit order per byte is {dp,g,f,e,d,c,b,a}.

## Operation
- Inputs are sampled only in cycles with `scan_done`=1. All other cycles leave the state unchanged.
- Debounce FSM, states IDLE, PRESS_CHK, HELD, REL_CHK:
  - IDLE: a hit loads the candidate code, sets cnt=1 and moves to PRESS_CHK. If DEBOUNCE_SCANS=1, it goes straight to HELD and emits the event.
  - PRESS_CHK: a hit with the same code increments cnt. When cnt reaches DEBOUNCE_SCANS, emit `key_event` and go to HELD. A hit with a different code reloads the candidate and sets cnt=1. No hit returns to IDLE.
  - HELD: no hit, or a hit with a different code, sets cnt=1 and moves to REL_CHK. A hit with the same code stays in HELD. Auto-repeat is never generated.
  - REL_CHK: no hit, or a different code, increments cnt. When cnt reaches DEBOUNCE_SCANS, go to IDLE. A hit with the held code returns to HELD.
  - A new press is accepted only after passing through IDLE.
- Buffer action on `key_event`; digit[0] is the rightmost digit (HEX0):
  - Digit key (0–D): shift the buffer left, load digit[0] with the code, and increment `entry_count`, saturating at NUM_DIGITS. When the buffer is full, the oldest digit falls off the top.
  - E (backspace): shift right, blank the top digit, and decrement `entry_count`. No effect when the count is 0.
  - F (clear): blank all digits and set `entry_count` to 0.
- Segment patterns per digit, active-low, dp always 1:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99
  - 5 92, 6 82, 7 F8, 8 80, 9 90
  - A 88, b 83, C C6, d A1
  - blank FF
- Digits at positions ≥ `entry_count` are blank.

## Timing
- A `scan_done` in cycle N that completes the press debounce causes:
  - `key_event`=1 and `key_last` and the buffer updated in cycle N+1;
  - `hex_out` (registered) updated in cycle N+2.
- `key_event` is never high in two consecutive cycles.
- Reset values:
  - `key_event` 0, `key_last` 0, `entry_count` 0;
  - all `hex_out` bytes FF;
  - FSM in IDLE, cnt 0, buffer blank.
- Reset asserted mid-debounce or mid-buffer-update clears everything immediately. No event is emitted on reset release.
- `scan_done` arriving in the same cycle as `key_event` is processed normally; the FSM is already in HELD.
- cnt is 4 bits and saturates; it never wraps.

## Structure
- Package `keypad_pkg` holds:
  - `KEY_BACK`=4'hE and `KEY_CLEAR`=4'hF;
  - the 16-entry segment constant set and `SEG_BLANK`=8'hFF;
  - the debounce state enum.
- Sub-module `key_debounce` contains the FSM and counter and outputs `key_event` and `key_last`.
- The top level holds the entry buffer and a registered per-digit decode, a `seg7_decode` instance per digit.

## Test plan
- Three hits of code 5 on consecutive `scan_done` pulses, then three no-hit scans → exactly one `key_event`, `key_last`=5, HEX0=92, `entry_count`=1.
- Two hits of 7 then one no-hit → no event, `hex_out` stays all FF.
- Press 1,2,3,4,5,6,7 with clean debounce → `entry_count`=6, HEX5..HEX0 = 2,3,4,5,6,7 (A4,B0,99,92,82,F8).
- Type 1,2 then E → `entry_count`=1, HEX0=F9, HEX1=FF. Then F → all FF, count 0. Then E → no change.
- Key 3 held for 20 scans → one event. Code switches to 8 mid-hold for 3 scans, then 3 no-hit scans → no event for 8, FSM returns to IDLE.
- Assert `rst_n`=0 while the FSM is in PRESS_CHK with 4 digits stored → outputs return to reset values asynchronously. After release, 2 further hits of the old code produce no event.
